// File: rtl/nibble_assembler_pkg.sv
// Shared definitions for the nibble selector / assembler datapath.
package nibble_assembler_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } asm_state_t;

endpackage

// File: rtl/nibble_out_slot.sv
// Single-entry valid/ready output register for assembled words.
// Optional word_parity port exists only when NIBBLE_ASSEMBLER_PARITY_EN is defined.
module nibble_out_slot #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_nibbles,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic [CNT_W-1:0]  word_nibbles,
    output logic              word_valid,
`ifdef NIBBLE_ASSEMBLER_PARITY_EN
    output logic              word_parity,
`endif
    output logic              slot_free
);

    // Free when empty, or when the sink takes the current word this cycle.
    assign slot_free = !word_valid || word_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            word_out     <= '0;
            word_nibbles <= '0;
            word_valid   <= 1'b0;
`ifdef NIBBLE_ASSEMBLER_PARITY_EN
            word_parity  <= 1'b0;
`endif
        end else if (load) begin
            word_out     <= load_word;
            word_nibbles <= load_nibbles;
            word_valid   <= 1'b1;
`ifdef NIBBLE_ASSEMBLER_PARITY_EN
            word_parity  <= ^load_word;
`endif
        end else if (word_ready) begin
            word_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_assembler.sv
// Packs a 4-bit nibble stream (first nibble in the LSBs) into NIBBLES-wide words,
// with flush support. Define NIBBLE_ASSEMBLER_PARITY_EN to add the word_parity port.
module nibble_assembler
    import nibble_assembler_pkg::*;
#(
    parameter  int NIBBLES = 8,
    localparam int WORD_W  = NIBBLE_W * NIBBLES,
    localparam int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [NIBBLE_W-1:0] nibble_in,
    input  logic                nibble_valid,
    output logic                nibble_ready,
    input  logic                flush,
    output logic [WORD_W-1:0]   word_out,
    output logic [CNT_W-1:0]    word_nibbles,
    output logic                word_valid,
`ifdef NIBBLE_ASSEMBLER_PARITY_EN
    output logic                word_parity,
`endif
    input  logic                word_ready
);

    asm_state_t        state, state_nxt;
    logic [WORD_W-1:0] acc, acc_nxt, acc_merged, load_word;
    logic [CNT_W-1:0]  cnt, cnt_nxt, eff_cnt, load_nibbles;
    logic              flush_pend, pend_nxt;
    logic              accept, complete, load, slot_free;

    assign accept   = nibble_valid && nibble_ready;
    assign eff_cnt  = cnt + CNT_W'(accept);
    assign complete = accept && (cnt == CNT_W'(NIBBLES - 1));

    always_comb begin
        acc_merged = acc;
        if (accept) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt == CNT_W'(i)) acc_merged[i*NIBBLE_W +: NIBBLE_W] = nibble_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= FILL;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        pend_nxt     = flush_pend || flush;
        load         = 1'b0;
        load_word    = acc_merged;
        load_nibbles = eff_cnt;
        case (state)
            FILL: begin
                if (complete) begin
                    // A full word absorbs any flush arriving with its last nibble.
                    load_nibbles = CNT_W'(NIBBLES);
                    pend_nxt     = flush_pend;
                    if (slot_free) begin
                        load    = 1'b1;
                        acc_nxt = '0;
                        cnt_nxt = '0;
                    end else begin
                        acc_nxt   = acc_merged;
                        state_nxt = HOLD;
                    end
                end else if (flush_pend && (eff_cnt != '0)) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        acc_nxt  = '0;
                        cnt_nxt  = '0;
                        pend_nxt = flush;
                    end else begin
                        acc_nxt = acc_merged;
                        cnt_nxt = eff_cnt;
                    end
                end else begin
                    acc_nxt  = acc_merged;
                    cnt_nxt  = eff_cnt;
                    pend_nxt = flush;
                end
            end
            HOLD: begin
                load_word    = acc;
                load_nibbles = CNT_W'(NIBBLES);
                if (slot_free) begin
                    load      = 1'b1;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Registered-only ready: a pending flush word blocks new nibbles until it leaves.
    always_comb begin
        nibble_ready = (state == FILL) && !(flush_pend && (cnt != '0));
    end

    nibble_out_slot #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_slot (
        .clk          (clk),
        .reset_L      (reset_L),
        .load         (load),
        .load_word    (load_word),
        .load_nibbles (load_nibbles),
        .word_ready   (word_ready),
        .word_out     (word_out),
        .word_nibbles (word_nibbles),
        .word_valid   (word_valid),
`ifdef NIBBLE_ASSEMBLER_PARITY_EN
        .word_parity  (word_parity),
`endif
        .slot_free    (slot_free)
    );

endmodule

// File: doc/nibble_assembler.md
# nibble_assembler

Downstream consumer of the nibble selector stage: collects the registered 4-bit nibbles it emits and packs them, first-arrived nibble in the least-significant position, into words of NIBBLES nibbles. Completed words leave through a valid/ready output port with a single-word output slot, and the block stalls the nibble stream through nibble_ready when that slot is blocked. A flush request emits a partially filled word, zero-padded, so a nibble stream can be closed at any length.

## Interface
- NIBBLES, 8: nibbles per output word; legal range 2..16. WORD_W = 4*NIBBLES.
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
- nibble_in  in  4  nibble from the selector stage.
- nibble_valid  in  1  nibble_in is meaningful this cycle.
- nibble_ready  out  1  block accepts a nibble this cycle. A transfer occurs on nibble_valid & nibble_ready.
- flush  in  1  single-cycle pulse: close the current partial word.
- word_out  out  WORD_W  assembled word.
- word_nibbles  out  $clog2(NIBBLES+1)  count of valid nibbles in word_out, 1..NIBBLES.
- word_valid  out  1  output slot holds a word.
- word_ready  in  1  sink accepts; a transfer occurs on word_valid & word_ready.
- word_parity  out  1  present only with the configuration macro (see Configuration).

## Operation
- Accumulator: register acc[WORD_W-1:0] plus count cnt (0..NIBBLES-1). An accepted nibble is written to acc[cnt*4 +: 4], then cnt increments.
- Output slot: word_out / word_nibbles / word_valid. The slot is "free" when !word_valid, or when word_valid & word_ready in the same cycle.
- States:
  - FILL: nibble_ready=1.
    - An accepted nibble that makes cnt reach NIBBLES is "completion". If the slot is free, the assembled word (acc with the new nibble merged in) loads into the slot, cnt goes to 0, and the state stays FILL. Otherwise the merged word stays in acc, and the state moves to HOLD.
  - HOLD: nibble_ready=0.
    - When the slot frees, acc moves into the slot with word_nibbles=NIBBLES, cnt=0, and the state returns to FILL.
- Flush:
  - A flush pulse sets flush_pend.
  - In FILL with flush_pend:
    - If cnt>0 (counting any nibble accepted in the same cycle) and the slot is free, load acc into the slot. Upper unfilled nibbles are 0 and word_nibbles=cnt. Then clear cnt, acc and flush_pend.
    - If cnt==0, clear flush_pend with no output.
  - Flush in HOLD, or when the slot is not free: flush_pend is held until served. In HOLD, the full word drains first; flush then sees cnt==0 and is discarded.
  - While flush_pend is set and a flush word is waiting for the slot, nibble_ready=0.
  - A nibble arriving together with the flush pulse is included in the flushed word. If that nibble completes the word, normal completion applies and the flush becomes a no-op.
- word_out, word_nibbles and word_valid hold stable while word_valid & !word_ready.

## Timing
- Reset (asynchronous assert, synchronous-release use assumed by the system):
  - acc=0, cnt=0, state FILL, flush_pend=0.
  - word_out=0, word_nibbles=0, word_valid=0, nibble_ready=1 (after reset_L deasserts). word_parity=0.
- Latency: completing nibble accepted at edge N, word_valid=1 after edge N, i.e. 1 cycle.
- Flush latency with a free slot: pulse sampled at edge N, word_valid=1 after edge N+1.
- Throughput: one nibble per cycle sustained while word_ready=1. The slot loads on the same edge it drains, so there is no bubble.
- nibble_ready is registered state only; it has no combinational path from word_ready.
- Reset mid-word discards acc and the slot contents immediately.

## Configuration
- NIBBLE_ASSEMBLER_PARITY_EN defined: port word_parity = XOR of word_out, registered with the slot, reset 0.
- Macro undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package: NIBBLE_W=4 constant and a state typedef {FILL, HOLD}. The selector stage reuses NIBBLE_W.
- One natural sub-module: nibble_out_slot, the single-entry valid/ready register holding word_out, word_nibbles and word_parity.

## Test plan
- Stream nibbles 1..8, word_ready=1 -> word_out=0x87654321, word_nibbles=8, word_valid one cycle after the 8th accept.
- Continuous 16 nibbles 0..F with word_ready=1 -> words 0x76543210 and 0xFEDCBA98 back-to-back, nibble_ready constantly 1.
- word_ready=0 while 16 nibbles are offered -> first word held stable, HOLD entered after the second completion, nibble_ready=0, no nibble lost. Raising word_ready drains both words in order.
- 3 nibbles A,B,C then flush -> word_out=0x00000CBA, word_nibbles=3. Flush with cnt==0 -> no word emitted.
- Flush pulse in the same cycle as 5th nibble 5 (after 1..4) -> word_out=0x00054321, word_nibbles=5.
- reset_L asserted mid-word with the slot full -> all outputs 0 immediately. After release, a fresh 8-nibble word assembles correctly. With the parity macro: 0x87654321 -> word_parity=1.
